prio_fifo_ctrl: RTL and testbench

Strict-priority multi-queue FIFO controller that owns one dual-port RAM (port A write-only, port B read-only) in the PRIO_FIFO_RAM path. The RAM is split into PRIO_NUM equal static partitions, one circular queue per priority. Queue 0 is the highest priority. The controller accepts tagged writes, tracks per-queue pointers and occupancy, and serves reads from the highest-priority non-empty queue with the RAM's one-cycle registered read latency.

---
 rtl/prio_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_prio_fifo_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_fifo_ctrl.sv
// Strict-priority multi-queue FIFO controller over a shared dual-port RAM, one static partition per queue.
// Optional dropped-write counter is built only when PRIO_FIFO_DROP_CNT_EN is defined.
module prio_fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int PRIO_NUM   = 4,
  localparam int QW        = $clog2(PRIO_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [QW-1:0]         wr_prio,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [QW-1:0]         rd_prio,
  output logic [PRIO_NUM-1:0]   full,
  output logic [PRIO_NUM-1:0]   empty,
  output logic [15:0]           drop_cnt,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  localparam int PW = ADDR_WIDTH - QW;
  localparam logic [PW:0] QD_CNT = (PW+1)'(1 << PW);

  logic [PW-1:0]       wptr [PRIO_NUM];
  logic [PW-1:0]       rptr [PRIO_NUM];
  logic [PW:0]         cnt  [PRIO_NUM];
  logic [QW-1:0]       sel;
  logic                found;
  logic                wr_acc;
  logic                rd_acc;
  logic [PRIO_NUM-1:0] wr_hit;
  logic [PRIO_NUM-1:0] rd_hit;

  // Per-queue status straight from occupancy.
  always_comb begin
    for (int q = 0; q < PRIO_NUM; q++) begin
      empty[q] = (cnt[q] == '0);
      full[q]  = (cnt[q] == QD_CNT);
    end
  end

  // Lowest-index non-empty queue wins the read.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < PRIO_NUM; i++) begin
      if (!found && !empty[i]) begin
        sel   = QW'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  assign wr_acc = rst_n & wr_en & ~full[wr_prio];
  assign rd_acc = rst_n & rd_req & found;

  // Per-queue hit vectors for the pointer/occupancy update.
  always_comb begin
    for (int q = 0; q < PRIO_NUM; q++) begin
      wr_hit[q] = wr_acc && (wr_prio == QW'(q));
      rd_hit[q] = rd_acc && (sel == QW'(q));
    end
  end

  assign ram_ena   = wr_acc;
  assign ram_wea   = wr_acc;
  assign ram_addra = {wr_prio, wptr[wr_prio]};
  assign ram_dina  = wr_data;
  assign ram_enb   = rd_acc;
  assign ram_web   = 1'b0;
  assign ram_addrb = {sel, rptr[sel]};
  assign rd_data   = ram_doutb;

  // Pointers, occupancy and read-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < PRIO_NUM; q++) begin
        wptr[q] <= '0;
        rptr[q] <= '0;
        cnt[q]  <= '0;
      end
      rd_valid <= 1'b0;
      rd_prio  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_prio <= sel;
      end else begin
        rd_prio <= rd_prio;
      end
      for (int q = 0; q < PRIO_NUM; q++) begin
        if (wr_hit[q]) begin
          wptr[q] <= wptr[q] + PW'(1);
        end else begin
          wptr[q] <= wptr[q];
        end
        if (rd_hit[q]) begin
          rptr[q] <= rptr[q] + PW'(1);
        end else begin
          rptr[q] <= rptr[q];
        end
        // Simultaneous write and read on one queue leave occupancy unchanged.
        case ({wr_hit[q], rd_hit[q]})
          2'b10:   cnt[q] <= cnt[q] + (PW+1)'(1);
          2'b01:   cnt[q] <= cnt[q] - (PW+1)'(1);
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

`ifdef PRIO_FIFO_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = rst_n & wr_en & full[wr_prio];

  // Saturating dropped-write counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 16'h0000;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'h0001;
    end else begin
      drop_q <= drop_q;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prio_fifo_ctrl.sv
// Self-checking bench for prio_fifo_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model and a behavioural RAM.
module tb_prio_fifo_ctrl;
  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_prio = 2'd0;
  logic [15:0] wr_data = 16'h0000;
  logic        rd_req = 1'b0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [1:0]  rd_prio;
  logic [3:0]  full, empty;
  logic [15:0] drop_cnt;
  logic        ram_ena, ram_wea, ram_enb, ram_web;
  logic [4:0]  ram_addra, ram_addrb;
  logic [15:0] ram_dina;
  logic [15:0] ram_doutb;
  logic [15:0] mem [32];

  int checks = 0;
  int passes = 0;

  prio_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_prio(wr_prio), .wr_data(wr_data),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_prio(rd_prio),
    .full(full), .empty(empty), .drop_cnt(drop_cnt),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem[ram_addrb];
  end

  // Reference model: one queue per priority plus totals for address prediction.
  logic [15:0] mq [4][$];
  int          wtot [4];
  int          rtot [4];
  int          drops;
  logic        exp_valid;
  logic [15:0] exp_data;
  logic [1:0]  exp_prio;
  logic        pre_wacc, pre_racc;
  int          pre_sel;
  logic [4:0]  pre_addra, pre_addrb;
  logic        obs_ena, obs_wea, obs_enb;
  logic [4:0]  obs_addra, obs_addrb;
  logic [15:0] obs_dina;

  function automatic logic [15:0] exp_drop();
`ifdef PRIO_FIFO_DROP_CNT_EN
    return (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [3:0] exp_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (mq[i].size() == 0);
    return e;
  endfunction

  function automatic logic [3:0] exp_full();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (mq[i].size() == QD);
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      wtot[i] = 0;
      rtot[i] = 0;
    end
    drops = 0;
    exp_valid = 1'b0;
    exp_prio = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_req = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock of stimulus, called at a negedge; records predictions and RAM-port observations.
  task automatic drive(input bit we, input int wp, input logic [15:0] wd, input bit rq);
    wr_en = we;
    wr_prio = wp[1:0];
    wr_data = wd;
    rd_req = rq;
    pre_wacc = we && (mq[wp].size() < QD);
    pre_sel = -1;
    for (int i = 0; i < 4; i++) if (pre_sel < 0 && mq[i].size() > 0) pre_sel = i;
    pre_racc = rq && (pre_sel >= 0);
    pre_addra = 5'(wp * QD + wtot[wp] % QD);
    pre_addrb = pre_racc ? 5'(pre_sel * QD + rtot[pre_sel] % QD) : 5'd0;
    #1;
    obs_ena = ram_ena; obs_wea = ram_wea; obs_addra = ram_addra; obs_dina = ram_dina;
    obs_enb = ram_enb; obs_addrb = ram_addrb;
    @(posedge clk);
    exp_valid = pre_racc;
    if (pre_racc) begin
      exp_data = mq[pre_sel].pop_front();
      exp_prio = 2'(pre_sel);
      rtot[pre_sel]++;
    end
    if (pre_wacc) begin
      mq[wp].push_back(wd);
      wtot[wp]++;
    end else if (we) begin
      drops++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_prio = 2'd1; rd_req = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ram_ena !== 1'b0 || ram_enb !== 1'b0) $display("FAIL reset_en: ena=%b enb=%b want 0 0", ram_ena, ram_enb); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else passes++;
    checks++; if (empty !== 4'b1111 || full !== 4'b0000) $display("FAIL reset_flags: empty=%b full=%b want 1111 0000", empty, full); else passes++;
    checks++; if (drop_cnt !== 16'h0000 || rd_prio !== 2'd0) $display("FAIL reset_cnt: drop=%h prio=%0d want 0 0", drop_cnt, rd_prio); else passes++;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0000, 1);
      checks++; if (obs_enb !== 1'b0 || rd_valid !== 1'b0) $display("FAIL idle_read: enb=%b valid=%b want 0 0", obs_enb, rd_valid); else passes++;
      checks++; if (empty !== 4'b1111) $display("FAIL idle_empty: got %b want 1111", empty); else passes++;
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1, 2, 16'h00A1, 0);
    drive(1, 0, 16'h00B0, 0);
    drive(0, 0, 16'h0000, 1);
    checks++; if (obs_enb !== 1'b1 || obs_addrb !== 5'b00000) $display("FAIL prio_addr0: enb=%b addr=%b want 1 00000", obs_enb, obs_addrb); else passes++;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h00B0 || rd_prio !== 2'd0) $display("FAIL prio_rd0: v=%b d=%h p=%0d want 1 00b0 0", rd_valid, rd_data, rd_prio); else passes++;
    drive(0, 0, 16'h0000, 1);
    checks++; if (obs_addrb !== 5'b10000) $display("FAIL prio_addr2: got %b want 10000", obs_addrb); else passes++;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h00A1 || rd_prio !== 2'd2) $display("FAIL prio_rd2: v=%b d=%h p=%0d want 1 00a1 2", rd_valid, rd_data, rd_prio); else passes++;
    drive(0, 0, 16'h0000, 0);
    checks++; if (rd_valid !== 1'b0 || empty !== 4'b1111) $display("FAIL prio_after: v=%b empty=%b want 0 1111", rd_valid, empty); else passes++;
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 16'(i), 0);
      if (i == 6) begin
        checks++; if (full[1] !== 1'b0) $display("FAIL full_early: got %b want 0", full[1]); else passes++;
      end
      if (i == 7) begin
        checks++; if (full[1] !== 1'b1) $display("FAIL full_set: got %b want 1", full[1]); else passes++;
      end
    end
    checks++; if (obs_ena !== 1'b0) $display("FAIL drop_noacc: ena=%b want 0", obs_ena); else passes++;
    checks++; if (drop_cnt !== exp_drop()) $display("FAIL drop_cnt: got %h want %h", drop_cnt, exp_drop()); else passes++;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 16'h0000, 1);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 16'(i) || rd_prio !== 2'd1) $display("FAIL full_rd%0d: v=%b d=%h p=%0d want 1 %h 1", i, rd_valid, rd_data, rd_prio, 16'(i)); else passes++;
    end
    checks++; if (empty[1] !== 1'b1 || full[1] !== 1'b0) $display("FAIL full_drain: empty=%b full=%b want 1 0", empty[1], full[1]); else passes++;
  endtask

  task automatic test_wrap();
    logic [4:0] want_addr [3];
    want_addr[0] = 5'b11110; want_addr[1] = 5'b11111; want_addr[2] = 5'b11000;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) drive(1, 3, 16'(16'h3000 + r * 16 + i), 0);
      for (int i = 0; i < 6; i++) begin
        drive(0, 0, 16'h0000, 1);
        if (r == 1 && i < 3) begin
          checks++; if (obs_addrb !== want_addr[i]) $display("FAIL wrap_addr%0d: got %b want %b", i, obs_addrb, want_addr[i]); else passes++;
        end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'(16'h3000 + r * 16 + i) || rd_prio !== 2'd3) $display("FAIL wrap_rd%0d_%0d: v=%b d=%h p=%0d", r, i, rd_valid, rd_data, rd_prio); else passes++;
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 0, 16'h5C5C, 1);
    checks++; if (obs_enb !== 1'b0 || obs_ena !== 1'b1) $display("FAIL same_en: enb=%b ena=%b want 0 1", obs_enb, obs_ena); else passes++;
    checks++; if (rd_valid !== 1'b0) $display("FAIL same_novalid: got %b want 0", rd_valid); else passes++;
    drive(0, 0, 16'h0000, 1);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h5C5C || rd_prio !== 2'd0) $display("FAIL same_rd: v=%b d=%h p=%0d want 1 5c5c 0", rd_valid, rd_data, rd_prio); else passes++;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    drive(1, 2, 16'h5A5A, 0);
    rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ram_enb !== 1'b0 || ram_ena !== 1'b0) $display("FAIL inflight_en: enb=%b ena=%b want 0 0", ram_enb, ram_ena); else passes++;
    @(posedge clk);
    #1;
    checks++; if (rd_valid !== 1'b0 || empty !== 4'b1111) $display("FAIL inflight_a: v=%b empty=%b want 0 1111", rd_valid, empty); else passes++;
    @(negedge clk);
    rd_req = 1'b0;
    rst_n = 1'b1;
    model_clear();
    drive(1, 1, 16'h7E7E, 0);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rd_valid !== 1'b1) $display("FAIL inflight_pre: v=%b want 1", rd_valid); else passes++;
    rst_n = 1'b0;
    rd_req = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0 || empty !== 4'b1111 || drop_cnt !== 16'h0000) $display("FAIL inflight_b: v=%b empty=%b drop=%h", rd_valid, empty, drop_cnt); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive(0, 0, 16'h0000, 1);
    checks++; if (obs_enb !== 1'b0 || rd_valid !== 1'b0 || empty !== 4'b1111) $display("FAIL inflight_after: enb=%b v=%b empty=%b", obs_enb, rd_valid, empty); else passes++;
  endtask

  task automatic test_random();
    int wpct, rpct;
    logic [15:0] wd;
    int wp;
    bit we, rq;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      case (c / 100)
        0: begin wpct = 85; rpct = 25; end
        1: begin wpct = 60; rpct = 60; end
        2: begin wpct = 20; rpct = 85; end
        default: begin wpct = 95; rpct = 50; end
      endcase
      we = ($urandom_range(99) < wpct);
      rq = ($urandom_range(99) < rpct);
      wp = (c / 100 == 3) ? 3 - int'($urandom_range(1)) : int'($urandom_range(3));
      wd = 16'($urandom);
      drive(we, wp, wd, rq);
      checks++; if (obs_ena !== pre_wacc || obs_wea !== pre_wacc) $display("FAIL rnd_ena c%0d: ena=%b wea=%b want %b", c, obs_ena, obs_wea, pre_wacc); else passes++;
      if (pre_wacc) begin
        checks++; if (obs_addra !== pre_addra || obs_dina !== wd) $display("FAIL rnd_addra c%0d: a=%b d=%h want %b %h", c, obs_addra, obs_dina, pre_addra, wd); else passes++;
      end
      checks++; if (obs_enb !== pre_racc) $display("FAIL rnd_enb c%0d: got %b want %b", c, obs_enb, pre_racc); else passes++;
      if (pre_racc) begin
        checks++; if (obs_addrb !== pre_addrb) $display("FAIL rnd_addrb c%0d: got %b want %b", c, obs_addrb, pre_addrb); else passes++;
      end
      checks++; if (rd_valid !== exp_valid || rd_prio !== exp_prio) $display("FAIL rnd_valid c%0d: v=%b p=%0d want %b %0d", c, rd_valid, rd_prio, exp_valid, exp_prio); else passes++;
      if (exp_valid) begin
        checks++; if (rd_data !== exp_data) $display("FAIL rnd_data c%0d: got %h want %h", c, rd_data, exp_data); else passes++;
      end
      checks++; if (empty !== exp_empty() || full !== exp_full()) $display("FAIL rnd_flags c%0d: empty=%b full=%b want %b %b", c, empty, full, exp_empty(), exp_full()); else passes++;
      checks++; if (drop_cnt !== exp_drop()) $display("FAIL rnd_drop c%0d: got %h want %h", c, drop_cnt, exp_drop()); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_full_drop();
    test_wrap();
    test_same_cycle();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
